// File: rtl/fifo_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_pkg
// Shared definitions for the FIFO write-side arbiter slice: FSM state
// encodings, default parameter values and small width helpers used by the
// interface, the priority picker and the arbiter top.
// ---------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arbState_e;

    localparam int DEF_N         = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Width of an index into N requesters; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value maxBurst.
    function automatic int burstCntWidth(input int maxBurst);
        return $clog2(maxBurst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
// Bundles the producer handshake and the FIFO write/occupancy signals seen by
// the arbiter.
//   req        producers -> arbiter  per-producer "word available"
//   req_data   producers -> arbiter  producer i word at [i*DW +: DW]
//   ack        arbiter -> producers  one-hot "word consumed this cycle"
//   fifo_full  FIFO -> arbiter       FIFO full flag
//   fifo_count FIFO -> arbiter       FIFO occupancy
//   write      arbiter -> FIFO       registered write strobe
//   buff_in    arbiter -> FIFO       registered write data
//   grant_id   arbiter -> observers  current/last grantee index
//   busy       arbiter -> observers  high while a burst is open
// The master side is the environment (producers plus FIFO); the slave side
// is the arbiter itself.
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int CNT_W = DEF_CNT_W
);

    localparam int IDX_W = idxWidth(N);

    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              write;
    logic [DW-1:0]     buff_in;
    logic [IDX_W-1:0]  grant_id;
    logic              busy;

    modport master (
        output req, req_data, fifo_full, fifo_count,
        input  ack, write, buff_in, grant_id, busy
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_count,
        output ack, write, buff_in, grant_id, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. Given a request vector and the index of
// the last grantee, returns the first requester found searching upward from
// last+1 and wrapping back to 0.
//   req_i    in   N      request vector
//   last_i   in   IDX_W  index of the most recent grantee
//   valid_o  out  1      at least one request is present
//   idx_o    out  IDX_W  chosen requester (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = idxWidth(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0] maskedReq;

    // Requests strictly above the last grantee form the preferred set; this
    // is what demotes the previous winner to lowest priority.
    always_comb begin
        maskedReq = '0;
        for (int i = 0; i < N; i++) begin
            maskedReq[i] = req_i[i] && (IDX_W'(i) > last_i);
        end
    end

    // Lowest-index search over the unmasked vector first, then over the
    // masked vector so a masked hit overrides; the unmasked result only
    // survives when nothing above last_i is requesting, giving the wrap.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (maskedReq[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Shares one FIFO write port between N producers with round-robin
// arbitration and bursts of up to MAX_BURST words per grant. The FIFO write
// strobe and data are registered, so an accepted word reaches the FIFO one
// cycle after its ack. Acceptance is throttled on occupancy, counting the
// in-flight write as already occupied, so the FIFO can never overflow.
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high
//   bus    slave modport of fifo_write_arbiter_if (handshake + FIFO side)
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic                 clk,
    input logic                 reset,
    fifo_write_arbiter_if.slave bus
);

    localparam int IDX_W = idxWidth(N);
    localparam int BW    = burstCntWidth(MAX_BURST);

    arbState_e        state_q, state_d;
    logic [IDX_W-1:0] grantId_q, grantId_d;
    logic [BW-1:0]    burstCnt_q, burstCnt_d;
    logic             write_q, write_d;
    logic [DW-1:0]    buffIn_q, buffIn_d;

    logic [N-1:0]     ackVec;
    logic [IDX_W-1:0] xferIdx;
    logic             pickValid;
    logic [IDX_W-1:0] pickIdx;
    logic [CNT_W:0]   occupied;
    logic             spaceOk;

    rr_priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) uPick (
        .req_i   (bus.req),
        .last_i  (grantId_q),
        .valid_o (pickValid),
        .idx_o   (pickIdx)
    );

    // Room check done one bit wider than the count so count + in-flight
    // write cannot wrap. FIFO reads in the same cycle are deliberately
    // ignored, which can only make the check pessimistic.
    always_comb begin
        occupied = {1'b0, bus.fifo_count} + (CNT_W + 1)'(write_q);
        spaceOk  = !bus.fifo_full && (occupied < (CNT_W + 1)'(DEPTH));
    end

    // Arbitration FSM. IDLE picks a new grantee round-robin; BURST keeps
    // serving the same grantee until it drops req or the burst cap is hit.
    // A full FIFO stalls either state without losing the grant. The ack is
    // forced low while reset is high so nothing is consumed that will not
    // be written.
    always_comb begin
        state_d    = state_q;
        grantId_d  = grantId_q;
        burstCnt_d = burstCnt_q;
        ackVec     = '0;
        xferIdx    = grantId_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pickValid && spaceOk) begin
                    ackVec     = N'(1) << pickIdx;
                    xferIdx    = pickIdx;
                    grantId_d  = pickIdx;
                    burstCnt_d = BW'(1);
                    state_d    = (MAX_BURST > 1) ? ST_BURST : ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!bus.req[grantId_q]) begin
                    state_d = ST_IDLE;
                end else if (spaceOk) begin
                    ackVec     = N'(1) << grantId_q;
                    burstCnt_d = burstCnt_q + BW'(1);
                    if (burstCnt_q + BW'(1) == BW'(MAX_BURST)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (reset) begin
            ackVec = '0;
        end
    end

    // The cycle after an ack drives the accepted word into the FIFO; the
    // data register simply holds its last value when no write is pending.
    always_comb begin
        write_d  = |ackVec;
        buffIn_d = buffIn_q;
        if (write_d) begin
            buffIn_d = bus.req_data[xferIdx*DW +: DW];
        end
    end

    // State and output registers. grant_id resets to N-1 so the first
    // arbitration after reset starts its search at requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grantId_q  <= IDX_W'(N - 1);
            burstCnt_q <= '0;
            write_q    <= 1'b0;
            buffIn_q   <= '0;
        end else begin
            state_q    <= state_d;
            grantId_q  <= grantId_d;
            burstCnt_q <= burstCnt_d;
            write_q    <= write_d;
            buffIn_q   <= buffIn_d;
        end
    end

    assign bus.ack      = ackVec;
    assign bus.write    = write_q;
    assign bus.buff_in  = buffIn_q;
    assign bus.grant_id = grantId_q;
    assign bus.busy     = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter with N=4, DEPTH=16, MAX_BURST=4.
// Producers are word queues that present their head word and advance on ack;
// a queue-based FIFO model sits behind the write port and feeds back its
// occupancy and full flag.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.N(N), .DW(DW), .CNT_W(CNT_W)) bus ();

    fifo_write_arbiter #(
        .N         (N),
        .DW        (DW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] prodMem [N][32];
    int         prodHead [N];
    int         prodTail [N];

    logic [7:0] fifoQ [$];
    int         maxCount;
    int         overflows;
    bit         popReq;

    logic [N-1:0] sAck;
    logic         sWrite;
    logic [7:0]   sBuf;
    logic [1:0]   sGrant;
    logic         sBusy;

    int   ackLog [$];
    int   ackCyc [$];
    logic busyLog [$];
    int   cycle;
    int   multiAck;

    int checks;
    int errors;

    function automatic logic [7:0] word(input int p, input int k);
        return 8'((p + 1) * 16 + k);
    endfunction

    // Present producer heads and FIFO status to the DUT.
    task automatic driveInputs();
        logic [N*DW-1:0] data;
        data = '0;
        for (int i = 0; i < N; i++) begin
            bus.req[i] = (prodHead[i] != prodTail[i]);
            data[i*DW +: DW] = prodMem[i][prodHead[i]];
        end
        bus.req_data   = data;
        bus.fifo_count = CNT_W'(fifoQ.size());
        bus.fifo_full  = (fifoQ.size() >= DEPTH);
    endtask

    // Queue nWords words for producer p, numbered from base.
    task automatic applyStimulus(input int p, input int nWords, input int base);
        for (int k = 0; k < nWords; k++) begin
            prodMem[p][prodTail[p]] = word(p, base + k);
            prodTail[p]++;
        end
        driveInputs();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // One clock: sample outputs on the falling edge, then after the rising
    // edge update the FIFO model and the producers, then re-drive inputs.
    task automatic tick();
        @(negedge clk);
        sAck   = bus.ack;
        sWrite = bus.write;
        sBuf   = bus.buff_in;
        sGrant = bus.grant_id;
        sBusy  = bus.busy;
        if (sAck != '0) begin
            if ($countones(sAck) != 1) multiAck++;
            for (int i = 0; i < N; i++) begin
                if (sAck[i]) ackLog.push_back(i);
            end
            ackCyc.push_back(cycle);
            busyLog.push_back(sBusy);
        end
        @(posedge clk);
        #1;
        if (sWrite === 1'b1) begin
            if (fifoQ.size() >= DEPTH) overflows++;
            else fifoQ.push_back(sBuf);
        end
        if (popReq && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            popReq = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (sAck[i] === 1'b1) prodHead[i]++;
        end
        if (fifoQ.size() > maxCount) maxCount = fifoQ.size();
        cycle++;
        driveInputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic runUntilAcks(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (ackLog.size() < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, ackLog.size(), target);
    endtask

    task automatic clearLogs();
        ackLog.delete();
        ackCyc.delete();
        busyLog.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        multiAck  = 0;
        overflows = 0;
        maxCount  = 0;
        popReq    = 1'b0;
        for (int i = 0; i < N; i++) begin
            prodHead[i] = 0;
            prodTail[i] = 0;
            for (int k = 0; k < 32; k++) prodMem[i][k] = '0;
        end
        reset = 1'b1;

        // Reset held two cycles with every producer requesting.
        for (int p = 0; p < N; p++) applyStimulus(p, 1, 0);
        tick();
        checkOutput("rst_ack_c1", sAck, 0);
        checkOutput("rst_write_c1", sWrite, 0);
        checkOutput("rst_grant_c1", sGrant, 3);
        checkOutput("rst_busy_c1", sBusy, 0);
        checkOutput("rst_buff_c1", sBuf, 0);
        tick();
        checkOutput("rst_ack_c2", sAck, 0);
        checkOutput("rst_write_c2", sWrite, 0);
        reset = 1'b0;
        clearLogs();

        // Round-robin: one word each, then a second round restarting at 0.
        tick();
        checkOutput("first_grant_ack", sAck, 4'b0001);
        runUntilAcks("rr_round1_acks", 4, 12);
        checkOutput("rr_order0", ackLog[0], 0);
        checkOutput("rr_order1", ackLog[1], 1);
        checkOutput("rr_order2", ackLog[2], 2);
        checkOutput("rr_order3", ackLog[3], 3);
        ticks(2);
        for (int p = 0; p < N; p++) applyStimulus(p, 1, 1);
        runUntilAcks("rr_round2_acks", 8, 12);
        checkOutput("rr_order4", ackLog[4], 0);
        checkOutput("rr_order7", ackLog[7], 3);
        ticks(3);
        checkOutput("rr_fifo_size", fifoQ.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("rr_fifo_word%0d", k), fifoQ[k], word(k % 4, k / 4));
        end

        // Burst cap: producer 1 with six words.
        fifoQ.delete();
        clearLogs();
        driveInputs();
        applyStimulus(1, 6, 0);
        runUntilAcks("burst_acks", 6, 12);
        begin
            int wrong;
            wrong = 0;
            foreach (ackLog[i]) if (ackLog[i] != 1) wrong++;
            checkOutput("burst_only_p1", wrong, 0);
        end
        checkOutput("burst_consecutive", ackCyc[5] - ackCyc[0], 5);
        checkOutput("burst_busy_w1", busyLog[0], 0);
        checkOutput("burst_busy_w4", busyLog[3], 1);
        checkOutput("burst_idle_rearb", busyLog[4], 0);
        ticks(3);
        checkOutput("burst_fifo_count", fifoQ.size(), 6);
        checkOutput("burst_fifo_last", fifoQ[5], word(1, 5));

        // Full: 15 words preloaded, producer 0 offers two.
        fifoQ.delete();
        for (int k = 0; k < 15; k++) fifoQ.push_back(8'hEE);
        maxCount = 15;
        clearLogs();
        driveInputs();
        applyStimulus(0, 2, 0);
        ticks(6);
        checkOutput("full_one_ack", ackLog.size(), 1);
        checkOutput("full_count16", fifoQ.size(), 16);
        checkOutput("full_stall_busy", sBusy, 1);
        popReq = 1'b1;
        runUntilAcks("full_ack_after_pop", 2, 2);
        checkOutput("full_second_p0", ackLog[1], 0);
        ticks(3);
        checkOutput("full_no_overflow", overflows, 0);
        checkOutput("full_max_count", maxCount, 16);
        checkOutput("full_final_count", fifoQ.size(), 16);
        checkOutput("full_last_word", fifoQ[15], word(0, 1));

        // Early release: producer 2 leaves after two words, producer 3 waits.
        fifoQ.delete();
        clearLogs();
        driveInputs();
        applyStimulus(2, 2, 0);
        applyStimulus(3, 1, 0);
        runUntilAcks("early_acks", 3, 10);
        checkOutput("early_g0", ackLog[0], 2);
        checkOutput("early_g1", ackLog[1], 2);
        checkOutput("early_g2", ackLog[2], 3);
        checkOutput("early_gap", ackCyc[2] - ackCyc[1], 2);
        checkOutput("early_idle_grant", busyLog[2], 0);

        // Reset on the cycle that would ack word 2 of a burst.
        ticks(3);
        fifoQ.delete();
        clearLogs();
        driveInputs();
        applyStimulus(1, 3, 0);
        tick();
        checkOutput("rmb_first_ack", sAck, 4'b0010);
        reset = 1'b1;
        tick();
        checkOutput("rmb_ack_suppressed", sAck, 0);
        checkOutput("rmb_word1_inflight", sWrite, 1);
        prodHead[1] = prodTail[1];
        driveInputs();
        tick();
        checkOutput("rmb_write_cleared", sWrite, 0);
        checkOutput("rmb_idle", sBusy, 0);
        checkOutput("rmb_grant_reset", sGrant, 3);
        reset = 1'b0;
        ticks(3);
        checkOutput("rmb_fifo_count", fifoQ.size(), 1);
        checkOutput("rmb_fifo_word", fifoQ[0], word(1, 0));
        checkOutput("rmb_ack_count", ackLog.size(), 1);

        checkOutput("onehot_ack", multiAck, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
